iomem_dbg_master: RTL and testbench

//  Byte-stream debug bridge that initiates iomem bus transactions (initiator end of iomem).

---
 rtl/iomem_dbg_master_pkg.sv | 17 +
 rtl/iomem_dbg_master.sv | 164 ++++++++++++++++
 tb/tb_iomem_dbg_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_dbg_master_pkg.sv
// Shared command/response codes and state encoding for the iomem debug bridge.
package iomem_dbg_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/iomem_dbg_master.sv
// Byte-stream debug bridge: decodes W/R commands from an rx byte stream, runs one
// iomem transaction per command and returns ACK/NAK or four read-data bytes on tx.
module iomem_dbg_master
    import iomem_dbg_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t        state, state_next;
    logic [1:0]    byte_cnt;
    logic          is_write;
    logic [TW-1:0] to_cnt;
    logic [31:0]   resp_buf;
    logic [1:0]    resp_left;

    logic rx_fire, tx_fire, bus_done, bus_timeout, last_operand;

    assign rx_fire      = rx_valid && rx_ready;
    assign tx_fire      = tx_valid && tx_ready;
    assign bus_done     = iomem_valid && iomem_ready;
    // Ready and timeout in the same cycle counts as success.
    assign bus_timeout  = iomem_valid && !iomem_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_operand = rx_fire && (byte_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        state_next = state;
        rx_ready   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                rx_ready = !reset;
                if (rx_fire && (rx_data == CMD_WR || rx_data == CMD_RD))
                    state_next = ST_ADDR;
            end
            ST_ADDR: begin
                rx_ready = !reset;
                if (last_operand)
                    state_next = is_write ? ST_DATA : ST_BUS;
            end
            ST_DATA: begin
                rx_ready = !reset;
                if (last_operand)
                    state_next = ST_BUS;
            end
            ST_BUS: begin
                if (bus_done || bus_timeout)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                if (tx_fire && resp_left == 2'd0)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= 2'd0;
            is_write    <= 1'b0;
            to_cnt      <= '0;
            resp_buf    <= 32'd0;
            resp_left   <= 2'd0;
            tx_data     <= 8'd0;
            tx_valid    <= 1'b0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'd0;
            iomem_addr  <= 32'd0;
            iomem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        is_write <= (rx_data == CMD_WR);
                        byte_cnt <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        iomem_addr <= {iomem_addr[23:0], rx_data};
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (last_operand && !is_write) begin
                            iomem_valid <= 1'b1;
                            iomem_wstrb <= 4'b0000;
                            to_cnt      <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        iomem_wdata <= {iomem_wdata[23:0], rx_data};
                        byte_cnt    <= byte_cnt + 2'd1;
                        if (last_operand) begin
                            iomem_valid <= 1'b1;
                            iomem_wstrb <= 4'b1111;
                            to_cnt      <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (bus_done) begin
                        iomem_valid <= 1'b0;
                        resp_buf    <= is_write ? {RSP_ACK, 24'd0} : iomem_rdata;
                        resp_left   <= is_write ? 2'd0 : 2'd3;
                    end else if (bus_timeout) begin
                        iomem_valid <= 1'b0;
                        resp_buf    <= {RSP_NAK, 24'd0};
                        resp_left   <= 2'd0;
                    end
                end
                ST_RESP: begin
                    // First byte is loaded one cycle after BUS exit; later bytes replace
                    // the accepted one on the same edge so a held tx_ready streams them.
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= resp_buf[31:24];
                        resp_buf <= {resp_buf[23:0], 8'd0};
                    end else if (tx_ready) begin
                        if (resp_left == 2'd0) begin
                            tx_valid <= 1'b0;
                        end else begin
                            tx_data   <= resp_buf[31:24];
                            resp_buf  <= {resp_buf[23:0], 8'd0};
                            resp_left <= resp_left - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_dbg_master.sv
// Self-checking bench for iomem_dbg_master: directed protocol cases plus randomized
// commands checked against a command-level model of bus transactions and tx bytes.
module tb_iomem_dbg_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    iomem_dbg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cycles;
    } txn_t;

    int          checks = 0;
    int          failures = 0;
    txn_t        txn_q[$];
    logic [7:0]  tx_q[$];
    int          cur_wait = 0;
    logic [31:0] cur_rdata = 32'd0;
    bit          junk_en = 0;
    bit          tx_hold = 0;
    bit          tx_rand = 0;
    int          vcnt = 0;
    bit          in_txn = 0;
    txn_t        cur;

    // Responder and bus monitor: ready after cur_wait stalled valid cycles (-1 = never).
    always @(negedge clk) begin
        if (reset) begin
            in_txn = 0;
            vcnt = 0;
            iomem_ready = 1'b0;
        end else if (iomem_valid) begin
            if (!in_txn) begin
                in_txn = 1;
                vcnt = 0;
                cur.addr = iomem_addr;
                cur.wdata = iomem_wdata;
                cur.wstrb = iomem_wstrb;
            end else begin
                checks++;
                if (iomem_addr !== cur.addr || iomem_wdata !== cur.wdata || iomem_wstrb !== cur.wstrb) begin
                    failures++;
                    $display("FAIL bus_stable: addr=%h wdata=%h wstrb=%h, required %h %h %h",
                             iomem_addr, iomem_wdata, iomem_wstrb, cur.addr, cur.wdata, cur.wstrb);
                end
            end
            vcnt++;
            iomem_ready = (cur_wait >= 0 && vcnt >= cur_wait + 1);
            iomem_rdata = iomem_ready ? cur_rdata : $urandom;
        end else begin
            if (in_txn) begin
                cur.cycles = vcnt;
                txn_q.push_back(cur);
                in_txn = 0;
            end
            iomem_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            iomem_rdata = $urandom;
        end
    end

    // tx sink: records each byte that will be accepted at the following posedge.
    always @(negedge clk) begin
        tx_ready = tx_hold ? 1'b0 : (tx_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (!reset && tx_valid && tx_ready)
            tx_q.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        #1;
        while (!rx_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!rx_ready) begin
            failures++;
            $display("FAIL rx_accept: rx_ready=%b after %0d cycles, required 1", rx_ready, g);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a, d;
        a = addr;
        d = data;
        send_byte(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[31 - 8*i -: 8]);
        if (wr) for (int i = 0; i < 4; i++) send_byte(d[31 - 8*i -: 8]);
    endtask

    task automatic wait_tx(input int n, input string name);
        int c = 0;
        while (tx_q.size() < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (tx_q.size() != n) begin
            failures++;
            $display("FAIL %s tx_count: got %0d bytes, required %0d", name, tx_q.size(), n);
        end
    endtask

    function automatic bit times_out(input int w);
        return (w < 0 || w >= TO);
    endfunction

    // Reference model: expected response bytes and bus transaction from the command alone.
    task automatic run_cmd(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input int wt, input logic [31:0] rdata,
                           input int hold);
        logic [7:0] exp_b[$];
        int         exp_cycles;
        int         c;
        bit         bad;
        cur_wait = wt;
        cur_rdata = rdata;
        tx_q.delete();
        txn_q.delete();
        if (times_out(wt)) exp_b.push_back(8'h15);
        else if (wr) exp_b.push_back(8'h06);
        else for (int i = 0; i < 4; i++) exp_b.push_back(8'((rdata >> (24 - 8*i)) & 32'hFF));
        exp_cycles = times_out(wt) ? TO : wt + 1;

        if (hold > 0) tx_hold = 1;
        send_cmd(wr, addr, data);
        if (hold > 0) begin
            c = 0;
            while (!tx_valid && c < 100) begin
                @(negedge clk);
                c++;
            end
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (tx_valid !== 1'b1 || tx_data !== exp_b[0] || rx_ready !== 1'b0) bad = 1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s hold: tx_valid=%b tx_data=%h rx_ready=%b, required 1 %h 0",
                         name, tx_valid, tx_data, rx_ready, exp_b[0]);
            end
            tx_hold = 0;
        end
        wait_tx(exp_b.size(), name);

        for (int i = 0; i < exp_b.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL %s tx_byte%0d: got %h, required %h", name, i, tx_q[i], exp_b[i]);
            end
        end
        checks++;
        if (txn_q.size() != 1) begin
            failures++;
            $display("FAIL %s txn_count: got %0d, required 1", name, txn_q.size());
        end else begin
            checks++;
            if (txn_q[0].addr !== addr || txn_q[0].wstrb !== (wr ? 4'hF : 4'h0) ||
                txn_q[0].cycles != exp_cycles || (wr && txn_q[0].wdata !== data)) begin
                failures++;
                $display("FAIL %s txn: addr=%h wdata=%h wstrb=%h cycles=%0d, required %h %h %h %0d",
                         name, txn_q[0].addr, txn_q[0].wdata, txn_q[0].wstrb, txn_q[0].cycles,
                         addr, data, wr ? 4'hF : 4'h0, exp_cycles);
            end
        end
        checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: busy=%b rx_ready=%b, required 0 1", name, busy, rx_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'd0 || iomem_valid !== 1'b0 ||
            iomem_wstrb !== 4'd0 || iomem_addr !== 32'd0 || iomem_wdata !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: rx_ready=%b tx_valid=%b tx_data=%h valid=%b wstrb=%h addr=%h wdata=%h busy=%b, required all 0",
                     name, rx_ready, tx_valid, tx_data, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency();
        cur_wait = 0;
        tx_q.delete();
        txn_q.delete();
        send_cmd(1'b1, 32'h0300_0000, 32'h0000_0003);
        checks++;
        if (iomem_valid !== 1'b1) begin
            failures++;
            $display("FAIL lat_valid: iomem_valid=%b one cycle after last byte, required 1", iomem_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0 || iomem_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_bus_exit: tx_valid=%b iomem_valid=%b, required 0 0", tx_valid, iomem_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
            failures++;
            $display("FAIL lat_ack: tx_valid=%b tx_data=%h three cycles after last byte, required 1 06",
                     tx_valid, tx_data);
        end
        wait_tx(1, "lat");
    endtask

    task automatic test_write();
        run_cmd("write", 1'b1, 32'h0300_0000, 32'h0000_0003, 0, 32'h0, 0);
    endtask

    task automatic test_read();
        run_cmd("read", 1'b0, 32'h0400_0010, 32'h0, 5, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_timeout();
        run_cmd("timeout", 1'b0, 32'h0BAD_0000, 32'h0, -1, 32'h1111_2222, 0);
        run_cmd("ready_at_limit", 1'b0, 32'h0000_0101, 32'h0, TO - 1, 32'h5566_7788, 0);
        run_cmd("ready_past_limit", 1'b1, 32'h0000_0202, 32'hA5A5_5A5A, TO, 32'h0, 0);
        run_cmd("after_timeout", 1'b1, 32'h0000_0303, 32'h0102_0304, 1, 32'h0, 0);
    endtask

    task automatic test_junk();
        tx_q.delete();
        txn_q.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (10) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || txn_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL junk: tx=%0d txn=%0d busy=%b, required 0 0 0", tx_q.size(), txn_q.size(), busy);
        end
        run_cmd("after_junk", 1'b1, 32'h0300_0004, 32'h0000_00FF, 0, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_cmd("backpressure", 1'b0, 32'h0400_0020, 32'h0, 2, 32'hDEAD_BEEF, 20);
    endtask

    task automatic test_reset_mid();
        int c;
        cur_wait = -1;
        send_cmd(1'b0, 32'h1234_5678, 32'h0);
        c = 0;
        while (!iomem_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("reset_in_bus");
        @(negedge clk);
        reset = 1'b0;

        cur_wait = 0;
        cur_rdata = 32'hCAFE_F00D;
        tx_q.delete();
        txn_q.delete();
        send_cmd(1'b0, 32'h0000_0040, 32'h0);
        c = 0;
        while (tx_q.size() < 1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("reset_in_resp");
        @(negedge clk);
        reset = 1'b0;
        #3;
        tx_q.delete();
        txn_q.delete();
        run_cmd("after_reset", 1'b0, 32'h0000_0044, 32'h0, 1, 32'h0BAD_CAFE, 0);
    endtask

    task automatic test_random();
        logic [7:0]  jb;
        logic [31:0] a, d, r;
        int          pick, wt;
        tx_rand = 1;
        junk_en = 1;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                jb = 8'($urandom);
                if (jb == 8'h57 || jb == 8'h52) jb = 8'h00;
                send_byte(jb);
            end
            a = $urandom;
            d = $urandom;
            r = $urandom;
            pick = $urandom_range(0, 9);
            case (pick)
                6: wt = TO - 1;
                7: wt = TO;
                8: wt = -1;
                9: wt = 3;
                default: wt = pick;
            endcase
            run_cmd($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), a, d, wt, r, 0);
        end
        tx_rand = 0;
        junk_en = 0;
    endtask

    initial begin
        rx_data = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        iomem_ready = 1'b0;
        iomem_rdata = 32'd0;
        test_reset();
        test_latency();
        test_write();
        test_read();
        test_timeout();
        test_junk();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
